johnson_phase_gen: RTL

Parametrised multi-phase Johnson counter for the DTC clock-phase path. It generates 2·STAGES evenly spaced phases for the PI digital frontend, with true and complement outputs. It extends the fixed 4-bit divide-by-4 counter with enable, direction control, synchronous clear, a registered phase tap, a wrap strobe, and illegal-state self-correction.

---
 rtl/johnson_phase_gen.sv | 121 ++++++++++++
 1 files changed

// File: rtl/johnson_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : johnson_phase_gen
// Brief    : Multi-phase Johnson counter with direction, clear, phase tap,
//            wrap strobe and illegal-state self-correction.
// Revision : 1.0 - initial release
// ============================================================================
module johnson_phase_gen #(
    parameter int STAGES = 4,
    parameter int CNT_W  = $clog2(2 * STAGES)
) (
    input  logic                  Clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  sync_clr,
    input  logic [CNT_W-1:0]      tap_sel,
    output logic [2*STAGES-1:0]   Count_out,
    output logic [CNT_W-1:0]      state_idx,
    output logic                  tap_out,
    output logic                  wrap,
    output logic                  illegal
);

    localparam int         c_NPH      = 2 * STAGES;
    localparam logic [CNT_W-1:0] c_IDX_LAST = CNT_W'(c_NPH - 1);

    logic [STAGES-1:0] r_q;
    logic              r_tap;
    logic              r_wrap;
    logic              r_illegal;

    logic [CNT_W:0]    w_pop;
    logic [CNT_W:0]    w_edges;
    logic              w_legal;
    logic [CNT_W-1:0]  w_idx;
    logic              w_tap;
    logic [STAGES-1:0] w_q_fwd;
    logic [STAGES-1:0] w_q_rev;
    logic              w_wrap_step;

    assign Count_out = {~r_q, r_q};

    // A Johnson pattern has at most one 0/1 boundary between adjacent bits;
    // anything with two or more is unreachable from a legal state.
    always_comb begin
        w_pop   = '0;
        w_edges = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_pop = w_pop + (CNT_W+1)'(r_q[i]);
        end
        for (int i = 0; i < STAGES - 1; i++) begin
            w_edges = w_edges + (CNT_W+1)'(r_q[i] ^ r_q[i+1]);
        end
    end

    assign w_legal = (w_edges <= (CNT_W+1)'(1));

    always_comb begin
        w_idx = '0;
        if (w_legal) begin
            if (r_q[STAGES-1]) begin
                w_idx = CNT_W'(c_NPH - int'(w_pop));
            end else begin
                w_idx = CNT_W'(w_pop);
            end
        end
    end

    assign state_idx = w_idx;

    // Selector values past the last phase bit fall through to zero.
    always_comb begin
        w_tap = 1'b0;
        for (int i = 0; i < c_NPH; i++) begin
            if (tap_sel == CNT_W'(i)) begin
                w_tap = Count_out[i];
            end
        end
    end

    assign w_q_fwd     = {r_q[STAGES-2:0], ~r_q[STAGES-1]};
    assign w_q_rev     = {~r_q[0], r_q[STAGES-1:1]};
    assign w_wrap_step = dir ? (w_idx == '0) : (w_idx == c_IDX_LAST);

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            r_wrap    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (sync_clr) begin
            r_q       <= '0;
            r_wrap    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!w_legal) begin
            r_q       <= '0;
            r_wrap    <= 1'b0;
            r_illegal <= 1'b1;
        end else if (en) begin
            r_q       <= dir ? w_q_rev : w_q_fwd;
            r_wrap    <= w_wrap_step;
        end else begin
            r_wrap    <= 1'b0;
        end
    end

    // The tap keeps sampling through a synchronous clear.
    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            r_tap <= 1'b0;
        end else begin
            r_tap <= w_tap;
        end
    end

    assign tap_out = r_tap;
    assign wrap    = r_wrap;
    assign illegal = r_illegal;

endmodule
`default_nettype wire
